// File: rtl/pool_pkg.sv
// Shared definitions for the pooling input buffer: FSM states and default word format.
package pool_pkg;

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } pool_state_e;

    localparam int DEFAULT_IL = 4;
    localparam int DEFAULT_FL = 16;

endpackage

// File: rtl/pool_input_buffer.sv
// Collects a frame of fixed-point words, hands it to the mean-pooling stage,
// guards the stage with a watchdog, and holds the resulting mean until it is taken.
module pool_input_buffer
    import pool_pkg::*;
#(
    parameter int IL    = DEFAULT_IL,
    parameter int FL    = DEFAULT_FL,
    parameter int size  = 4,
    parameter int width = $clog2(size)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IL+FL-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic [size-1:0][IL+FL-1:0]     im,
    output logic                           en,
    output logic                           input_ready,
    input  logic                           pool_done,
    input  logic [IL+FL-1:0]               pool_om,
    output logic [IL+FL-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           err,
    output logic [15:0]                    frame_cnt
);

    localparam int                DW         = IL + FL;
    localparam int                WDW        = width + 2;
    localparam logic [width-1:0]  LAST_PTR   = width'(size - 1);
    localparam logic [WDW-1:0]    WDOG_LIMIT = WDW'(size + 2);

    pool_state_e                 state_q, state_d;
    logic [width-1:0]            wr_ptr_q, wr_ptr_d;
    logic [WDW-1:0]              wdog_q, wdog_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]               out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        err_q, err_d;
    logic [size-1:0][DW-1:0]     im_q, im_d;
    logic                        live_q;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            wdog_q      <= '0;
            frame_cnt_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            im_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wdog_q      <= wdog_d;
            frame_cnt_q <= frame_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            im_q        <= im_d;
        end
    end

    // Next-state and handshake logic; the frame only changes while filling.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wdog_d      = wdog_q;
        frame_cnt_d = frame_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        im_d        = im_q;
        in_ready    = 1'b0;
        en          = 1'b0;
        input_ready = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = live_q;
                wdog_d   = '0;
                if (flush) begin
                    wr_ptr_d = '0;
                end else if (in_valid && live_q) begin
                    im_d[wr_ptr_q] = in_data;
                    wr_ptr_d       = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                en          = 1'b1;
                input_ready = 1'b1;
                wdog_d      = '0;
                state_d     = RUN;
            end
            RUN: begin
                en     = 1'b1;
                wdog_d = wdog_q + 1'b1;
                if (pool_done) begin
                    state_d = CAPTURE;
                end else if (wdog_d == WDOG_LIMIT) begin
                    err_d    = 1'b1;
                    wr_ptr_d = '0;
                    state_d  = FILL;
                end
            end
            CAPTURE: begin
                en          = 1'b1;
                out_data_d  = pool_om;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    wr_ptr_d    = '0;
                    state_d     = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign im        = im_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
